axi_lite_master_dual: RTL

AXI_LITE_MASTER_DUAL -- requirements
Module: axi_lite_master_dual

---
 rtl/axi_lite_master_dual.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master_dual.sv
// AXI4-Lite master with independent write and read engines.
// Each engine runs one transaction at a time and aborts on a stall timeout.
module axi_lite_master_dual #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    // write address channel
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    // write data channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    // write response channel
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    // read data channel
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    // user write command
    input  logic                    write_req,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_ready,
    output logic                    write_done,
    output logic [1:0]              write_resp,
    output logic                    write_timeout,
    // user read command
    input  logic                    read_req,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic                    read_ready,
    output logic                    read_done,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic [1:0]              read_resp,
    output logic                    read_timeout
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rstate_e;

    // write engine state
    wstate_e                 wstate_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic                    awvalid_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [SW-1:0]           wstrb_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic                    write_done_q;
    logic [1:0]              write_resp_q;
    logic                    write_timeout_q;
    logic [CW-1:0]           wcnt_q;
    logic [CW-1:0]           wcnt_d;

    // read engine state
    rstate_e                 rstate_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    read_done_q;
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic [1:0]              read_resp_q;
    logic                    read_timeout_q;
    logic [CW-1:0]           rcnt_q;
    logic [CW-1:0]           rcnt_d;

    // handshakes and terminal-count flags
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic aw_ok;
    logic w_ok;
    logic w_term;
    logic r_term;

    assign aw_hs  = awvalid_q & awready;
    assign w_hs   = wvalid_q & wready;
    assign b_hs   = bready_q & bvalid;
    assign ar_hs  = arvalid_q & arready;
    assign r_hs   = rready_q & rvalid;

    // address or data phase finished now or earlier
    assign aw_ok  = aw_done_q | aw_hs;
    assign w_ok   = w_done_q | w_hs;

    assign w_term = TO_EN && (wcnt_q == CNT_LAST);
    assign r_term = TO_EN && (rcnt_q == CNT_LAST);

    assign write_ready   = (wstate_q == W_IDLE);
    assign read_ready    = (rstate_q == R_IDLE);

    assign awaddr        = awaddr_q;
    assign awvalid       = awvalid_q;
    assign wdata         = wdata_q;
    assign wstrb         = wstrb_q;
    assign wvalid        = wvalid_q;
    assign bready        = bready_q;
    assign write_done    = write_done_q;
    assign write_resp    = write_resp_q;
    assign write_timeout = write_timeout_q;

    assign araddr        = araddr_q;
    assign arvalid       = arvalid_q;
    assign rready        = rready_q;
    assign read_done     = read_done_q;
    assign read_data     = read_data_q;
    assign read_resp     = read_resp_q;
    assign read_timeout  = read_timeout_q;

    // stall counters: zero while idle, saturate at the terminal count
    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (wstate_q == W_IDLE) begin
            wcnt_d = '0;
        end else if (wcnt_q != CNT_LAST) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (rstate_q == R_IDLE) begin
            rcnt_d = '0;
        end else if (rcnt_q != CNT_LAST) begin
            rcnt_d = rcnt_q + 1'b1;
        end
    end

    // stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    // write engine: issue AW and W together, then collect B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q        <= W_IDLE;
            awaddr_q        <= '0;
            awvalid_q       <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            write_done_q    <= 1'b0;
            write_resp_q    <= 2'b00;
            write_timeout_q <= 1'b0;
        end else begin
            write_done_q <= 1'b0;
            unique case (wstate_q)
                W_IDLE: begin
                    if (write_req) begin
                        wstate_q  <= W_ISSUE;
                        awaddr_q  <= write_addr;
                        wdata_q   <= write_data;
                        wstrb_q   <= write_strb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                W_ISSUE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        wstate_q <= W_RESP;
                        bready_q <= 1'b1;
                    end else if (w_term && !aw_hs && !w_hs) begin
                        wstate_q        <= W_IDLE;
                        awvalid_q       <= 1'b0;
                        wvalid_q        <= 1'b0;
                        bready_q        <= 1'b0;
                        write_done_q    <= 1'b1;
                        write_resp_q    <= RESP_SLVERR;
                        write_timeout_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        wstate_q        <= W_IDLE;
                        bready_q        <= 1'b0;
                        write_done_q    <= 1'b1;
                        write_resp_q    <= bresp;
                        write_timeout_q <= 1'b0;
                    end else if (w_term) begin
                        wstate_q        <= W_IDLE;
                        bready_q        <= 1'b0;
                        write_done_q    <= 1'b1;
                        write_resp_q    <= RESP_SLVERR;
                        write_timeout_q <= 1'b1;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase
        end
    end

    // read engine: issue AR, then collect R
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q       <= R_IDLE;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            read_done_q    <= 1'b0;
            read_data_q    <= '0;
            read_resp_q    <= 2'b00;
            read_timeout_q <= 1'b0;
        end else begin
            read_done_q <= 1'b0;
            unique case (rstate_q)
                R_IDLE: begin
                    if (read_req) begin
                        rstate_q  <= R_ADDR;
                        araddr_q  <= read_addr;
                        arvalid_q <= 1'b1;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) begin
                        rstate_q  <= R_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end else if (r_term) begin
                        rstate_q       <= R_IDLE;
                        arvalid_q      <= 1'b0;
                        rready_q       <= 1'b0;
                        read_done_q    <= 1'b1;
                        read_resp_q    <= RESP_SLVERR;
                        read_timeout_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rstate_q       <= R_IDLE;
                        rready_q       <= 1'b0;
                        read_done_q    <= 1'b1;
                        read_data_q    <= rdata;
                        read_resp_q    <= rresp;
                        read_timeout_q <= 1'b0;
                    end else if (r_term) begin
                        rstate_q       <= R_IDLE;
                        rready_q       <= 1'b0;
                        read_done_q    <= 1'b1;
                        read_resp_q    <= RESP_SLVERR;
                        read_timeout_q <= 1'b1;
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

endmodule
